// File: rtl/stream_demux_1_4.sv
// 1-to-4 stream demultiplexer: each upstream word is steered to the channel named by up_sel,
// where it is held in a one-entry output register with a valid/ready handshake.
module stream_demux_1_4 #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [WIDTH-1:0] up_data,
   input  logic [1:0]       up_sel,
   output logic [3:0]       down_valid,
   input  logic [3:0]       down_ready,
   output logic [WIDTH-1:0] down_data0,
   output logic [WIDTH-1:0] down_data1,
   output logic [WIDTH-1:0] down_data2,
   output logic [WIDTH-1:0] down_data3,
   output logic [CNT_W-1:0] xfer_cnt
);

   logic [3:0]       full_r;
   logic [WIDTH-1:0] data_r [4];
   logic [CNT_W-1:0] cnt_r;
   logic             accept_s;
   logic [3:0]       write_s;
   logic [3:0]       drain_s;

   // Ready and per-channel write/drain strobes.
   // A full channel that drains this cycle can take a new word, which gives one word per clock.
   always_comb begin
      up_ready = 1'b0;
      write_s  = 4'b0000;
      if (rst) begin
         up_ready = 1'b0;
      end else begin
         up_ready = !full_r[up_sel] || down_ready[up_sel];
      end
      accept_s = up_valid && up_ready;
      if (accept_s) begin
         write_s = 4'b0001 << up_sel;
      end else begin
         write_s = 4'b0000;
      end
      drain_s = full_r & down_ready;
   end

   // Channel registers and accepted-word counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_r <= 4'b0000;
         cnt_r  <= '0;
         for (int i = 0; i < 4; i++) begin
            data_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (write_s[i]) begin
               full_r[i] <= 1'b1;
               data_r[i] <= up_data;
            end else if (drain_s[i]) begin
               full_r[i] <= 1'b0;
            end else begin
               full_r[i] <= full_r[i];
            end
         end
         if (accept_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign down_valid = full_r;
   assign down_data0 = data_r[0];
   assign down_data1 = data_r[1];
   assign down_data2 = data_r[2];
   assign down_data3 = data_r[3];
   assign xfer_cnt   = cnt_r;

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Self-checking bench for stream_demux_1_4: directed scenarios plus randomized traffic,
// compared against a per-channel slot model.
module tb_stream_demux_1_4;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             up_valid;
   logic             up_ready;
   logic [WIDTH-1:0] up_data;
   logic [1:0]       up_sel;
   logic [3:0]       down_valid;
   logic [3:0]       down_ready;
   logic [WIDTH-1:0] down_data0, down_data1, down_data2, down_data3;
   logic [CNT_W-1:0] xfer_cnt;

   int checks;
   int failures;

   // Reference model: which slots hold a word, what word, and how many were accepted.
   logic [3:0]       m_full;
   logic [WIDTH-1:0] m_data [4];
   int               m_cnt;

   stream_demux_1_4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_sel(up_sel),
      .down_valid(down_valid), .down_ready(down_ready),
      .down_data0(down_data0), .down_data1(down_data1),
      .down_data2(down_data2), .down_data3(down_data3),
      .xfer_cnt(xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] chan_data(input int i);
      case (i)
         0: return down_data0;
         1: return down_data1;
         2: return down_data2;
         default: return down_data3;
      endcase
   endfunction

   task automatic model_clear();
      m_full = 4'b0000;
      m_cnt  = 0;
      for (int i = 0; i < 4; i++) m_data[i] = '0;
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, "_valid"}, 32'(down_valid), 32'(m_full));
      for (int i = 0; i < 4; i++) begin
         if (m_full[i]) check_val($sformatf("%s_data%0d", tag, i), 32'(chan_data(i)), 32'(m_data[i]));
      end
      check_val({tag, "_cnt"}, 32'(xfer_cnt), 32'(m_cnt));
   endtask

   // One clock: drive at the falling edge, check ready, then check registered outputs after the rise.
   task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic [1:0] s,
                       input logic [3:0] dr, input string tag, output logic acc);
      logic exp_rdy;
      @(negedge clk);
      up_valid = v; up_data = d; up_sel = s; down_ready = dr;
      #1;
      exp_rdy = !m_full[s] || dr[s];
      check_val({tag, "_up_ready"}, 32'(up_ready), 32'(exp_rdy));
      acc = v && exp_rdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (acc && (int'(s) == i)) begin
            m_full[i] = 1'b1;
            m_data[i] = d;
         end else if (m_full[i] && dr[i]) begin
            m_full[i] = 1'b0;
         end
      end
      if (acc) m_cnt = (m_cnt + 1) % 256;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      up_valid = 1'b0; down_ready = 4'b0000;
      #1;
      model_clear();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic acc;
      logic pend;
      logic v;
      logic [WIDTH-1:0] pd;
      logic [1:0] ps;
      checks = 0; failures = 0;
      rst = 1'b1; up_valid = 1'b0; up_data = '0; up_sel = 2'd0; down_ready = 4'b0000;
      model_clear();
      #2;
      check_val("rst_valid", 32'(down_valid), 32'h0);
      check_val("rst_cnt", 32'(xfer_cnt), 32'h0);
      check_val("rst_up_ready", 32'(up_ready), 32'h0);
      @(negedge clk); rst = 1'b0;

      // Route a,b,c,d to channels 0..3 with every consumer ready.
      step(1'b1, 4'ha, 2'd0, 4'b1111, "p1a", acc);
      check_val("p1a_d0", 32'(down_data0), 32'ha);
      step(1'b1, 4'hb, 2'd1, 4'b1111, "p1b", acc);
      step(1'b1, 4'hc, 2'd2, 4'b1111, "p1c", acc);
      step(1'b1, 4'hd, 2'd3, 4'b1111, "p1d", acc);
      check_val("p1_d3", 32'(down_data3), 32'hd);
      check_val("p1_cnt4", 32'(xfer_cnt), 32'd4);
      step(1'b0, 4'h0, 2'd0, 4'b1111, "p1e", acc);
      check_val("p1_empty", 32'(down_valid), 32'h0);

      // Channel 1 backpressured: second word stalls until the consumer is ready.
      step(1'b1, 4'h5, 2'd1, 4'b1101, "p2a", acc);
      step(1'b1, 4'h6, 2'd1, 4'b1101, "p2b", acc);
      check_val("p2_stalled", 32'(acc), 32'h0);
      check_val("p2_hold", 32'(down_data1), 32'h5);
      step(1'b1, 4'h6, 2'd1, 4'b1111, "p2c", acc);
      check_val("p2_new", 32'(down_data1), 32'h6);
      step(1'b0, 4'h0, 2'd0, 4'b1111, "p2d", acc);

      // Channel 2 stuck full does not block traffic to channel 0.
      step(1'b1, 4'h3, 2'd2, 4'b1011, "p3a", acc);
      step(1'b1, 4'h7, 2'd0, 4'b1011, "p3b", acc);
      check_val("p3_d0_7", 32'(down_data0), 32'h7);
      step(1'b1, 4'h8, 2'd0, 4'b1011, "p3c", acc);
      check_val("p3_d0_8", 32'(down_data0), 32'h8);
      check_val("p3_d2", 32'(down_data2), 32'h3);
      check_val("p3_v2", 32'(down_valid[2]), 32'h1);

      // Continuous streaming into channel 3.
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(i), 2'd3, 4'b1000, "p4", acc);
      check_val("p4_cnt10", 32'(xfer_cnt), 32'd10);

      // Counter wrap after 260 accepted words.
      do_reset();
      for (int i = 0; i < 260; i++)
         step(1'b1, WIDTH'($urandom), 2'($urandom), 4'b1111, "p5", acc);
      check_val("p5_wrap", 32'(xfer_cnt), 32'd4);

      // Randomized traffic; a stalled word is held until accepted.
      pend = 1'b0; pd = '0; ps = 2'd0;
      for (int i = 0; i < 500; i++) begin
         if (!pend) begin
            v  = ($urandom_range(0, 3) != 0);
            pd = WIDTH'($urandom);
            ps = 2'($urandom);
         end else begin
            v = 1'b1;
         end
         step(v, pd, ps, 4'($urandom), "rnd", acc);
         pend = v && !acc;
      end

      // Asynchronous reset mid-cycle with channels 0 and 2 full.
      do_reset();
      step(1'b1, 4'h9, 2'd0, 4'b0000, "p6a", acc);
      step(1'b1, 4'ha, 2'd2, 4'b0000, "p6b", acc);
      check_val("p6_full", 32'(down_valid), 32'h5);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      model_clear();
      check_val("p6_valid0", 32'(down_valid), 32'h0);
      check_val("p6_d0", 32'(down_data0), 32'h0);
      check_val("p6_d2", 32'(down_data2), 32'h0);
      check_val("p6_cnt", 32'(xfer_cnt), 32'h0);
      up_valid = 1'b1; up_sel = 2'd1; down_ready = 4'b1111;
      #1;
      check_val("p6_up_ready_rst", 32'(up_ready), 32'h0);
      @(negedge clk);
      up_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_val("p6_up_ready_rel", 32'(up_ready), 32'h1);
      check_outputs("p6_post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
- 1-to-4 stream demultiplexer: routes each upstream word to one of four downstream channels selected by a per-word 2-bit channel index. This is the distribution counterpart of the 4:1 mux used on the collection side.
- Each downstream channel has a one-entry output register with a valid/ready handshake, so all outputs are registered.
- Includes a wrapping counter of accepted words for debug and verification.

Parameters:
- WIDTH, 4, data width of the upstream word and of each downstream channel.
- CNT_W, 8, width of the accepted-word counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- up_valid  input  1  upstream word valid.
- up_ready  output  1  upstream ready; combinational.
- up_data  input  WIDTH  upstream word.
- up_sel  input  2  destination channel (0..3) for up_data.
- down_valid  output  4  bit i = channel i holds a word.
- down_ready  input  4  bit i = channel i consumer accepts this cycle.
- down_data0..down_data3  output  WIDTH each  channel data, registered.
- xfer_cnt  output  CNT_W  count of accepted upstream words, wraps.

Behaviour:
- Reset:
  - Asynchronous, active-high: clk and rst as stated; rst asserts asynchronously and takes effect immediately.
  - While rst is high: down_valid=0, all down_data=0, xfer_cnt=0.
  - Reset mid-operation discards every buffered word with no drain.
  - up_ready is 0 while rst is high.
- Per-channel state: full[i] (= down_valid[i]) and data register d[i].
- up_ready = !rst && (!full[up_sel] || down_ready[up_sel]).
  - Combinational from up_sel and down_ready.
  - Independent of up_valid.
- Accept when up_valid && up_ready. On the next edge:
  - d[up_sel] <= up_data and full[up_sel] <= 1.
  - xfer_cnt increments by 1, modulo 2^CNT_W (255 -> 0 at the default width).
- Drain on channel i when full[i] && down_ready[i]. On the next edge full[i] <= 0, unless channel i is simultaneously written by an accept.
- Simultaneous drain and write of the same channel: full stays 1, d takes the new word. This gives full throughput of 1 word/clock per channel.
- Drains on different channels are independent; all four may drain in the same cycle.
- Latency: a word accepted at edge N is visible on down_valid/down_data at edge N.
  - Zero extra cycles after the accept edge.
  - First observation is one cycle after up_valid is presented.
- Stability: while down_valid[i]=1 && down_ready[i]=0, down_data_i holds unchanged.
  - d[i] never changes unless channel i is the accept target.
- Channels not selected by up_sel are unaffected by upstream activity.
- Backpressure on the selected channel does not block other channels from draining.
  - Upstream stalls until the selected channel frees; there is no reordering or lookahead.
- up_valid with up_ready=0: nothing changes.
  - The upstream must hold up_data and up_sel stable until accepted.
  - The block does not check this.
- down_ready=1 on an empty channel has no effect.
- Per-channel order is preserved trivially because each channel holds only one entry.
- No combinational path from up_valid or up_data to any down_* output.

Test Plan:
- Reset, then route 'ha,'hb,'hc,'hd to sel 0,1,2,3 on consecutive clocks with down_ready=4'b1111 -> each down_valid[i] pulses 1 cycle with data a/b/c/d in order; xfer_cnt=4.
- Hold down_ready[1]=0, send 'h5 then 'h6 to sel 1 -> 'h5 is captured; up_ready=0 on the next cycle and down_data1 stays 'h5. Raise down_ready[1] -> the same cycle accepts 'h6 and down_data1='h6 next clock.
- Channel 2 blocked full with 'h3 while words 'h7 and 'h8 are sent to sel 0 -> both are delivered on channel 0 with up_ready=1; channel 2 still shows 'h3.
- Continuous streaming to sel 3 with down_ready[3]=1 for 10 clocks -> up_ready stays 1; one word per clock out in order; xfer_cnt=10.
- Send 260 words with all channels ready -> xfer_cnt wraps to 4.
- Assert rst asynchronously (mid-cycle) with channels 0 and 2 full -> down_valid=0 and all down_data=0 immediately, before the next edge; xfer_cnt=0; up_ready=0 until rst falls.
